vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator for the game display path. Drives the monitor's H/V sync pins and feeds pixel coordinates to the sprite/colour logic. Runs on the 100 MHz system clock with an internal pixel clock-enable divider, replacing the fixed 640x480 counters. Supports any resolution, sync polarity and divide ratio.

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/clk_en_div.sv | 33 +++
 rtl/vga_timing_gen.sv | 154 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and colour-bar helpers for the VGA raster path.
// Defaults describe 640x480@60 driven from a 100 MHz system clock (divide by 4).
// No ports: the package provides localparams and the bar_rgb() colour lookup.
package vga_pkg;

  // 640x480@60 timing (pixels / lines)
  localparam int unsigned VgaClkDiv  = 4;
  localparam int unsigned VgaHActive = 640;
  localparam int unsigned VgaHFp     = 16;
  localparam int unsigned VgaHSync   = 96;
  localparam int unsigned VgaHBp     = 48;
  localparam int unsigned VgaVActive = 480;
  localparam int unsigned VgaVFp     = 10;
  localparam int unsigned VgaVSync   = 2;
  localparam int unsigned VgaVBp     = 33;
  localparam int unsigned VgaCw      = 11;

  // Bar colours as {r, g, b}, 4 bits per channel
  localparam logic [11:0] ColWhite   = 12'hFFF;
  localparam logic [11:0] ColYellow  = 12'hFF0;
  localparam logic [11:0] ColCyan    = 12'h0FF;
  localparam logic [11:0] ColGreen   = 12'h0F0;
  localparam logic [11:0] ColMagenta = 12'hF0F;
  localparam logic [11:0] ColRed     = 12'hF00;
  localparam logic [11:0] ColBlue    = 12'h00F;
  localparam logic [11:0] ColBlack   = 12'h000;

  // Colour of bar idx, left (0) to right (7)
  function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
    logic [11:0] col;
    col = ColBlack;
    unique case (idx)
      3'd0: col = ColWhite;
      3'd1: col = ColYellow;
      3'd2: col = ColCyan;
      3'd3: col = ColGreen;
      3'd4: col = ColMagenta;
      3'd5: col = ColRed;
      3'd6: col = ColBlue;
      3'd7: col = ColBlack;
      default: col = ColBlack;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Pixel clock-enable divider. Counts 0..DIV-1 and asserts tick (combinationally)
// while the count sits at DIV-1, so the tick edge is the one that wraps the count.
// DIV=1 leaves the counter at 0 and tick permanently high.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset (count returns to 0)
//   tick  - high during the clock whose rising edge is a pixel step
module clk_en_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(DIV - 1);

  logic [DW-1:0] div_q;

  assign tick = (div_q == DivLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// A clk_en_div instance produces the pixel step; on each step the h/v counters
// advance and every output is re-registered from the new h/v values, so outputs
// change together one clock after the step edge and hold until the next step.
// Optional build macro: VGA_TEST_PATTERN_EN adds r/g/b outputs carrying eight
// vertical colour bars over the visible area.
// Ports:
//   clk, rst_n          - system clock, synchronous active-low reset
//   hsync, vsync        - sync pins, asserted level HS_POL / VS_POL
//   pix_en              - one-clk strobe: new position presented
//   active              - position inside the visible area
//   x, y                - raw h/v counts (including blanking)
//   line_start          - pix_en strobe when x wraps to 0
//   frame_start         - pix_en strobe at x=0, y=0
//   r, g, b             - test pattern colour (VGA_TEST_PATTERN_EN only)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VgaClkDiv,
  parameter int unsigned H_ACTIVE = VgaHActive,
  parameter int unsigned H_FP     = VgaHFp,
  parameter int unsigned H_SYNC   = VgaHSync,
  parameter int unsigned H_BP     = VgaHBp,
  parameter int unsigned V_ACTIVE = VgaVActive,
  parameter int unsigned V_FP     = VgaVFp,
  parameter int unsigned V_SYNC   = VgaVSync,
  parameter int unsigned V_BP     = VgaVBp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = VgaCw
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          hsync,
  output logic          vsync,
  output logic          pix_en,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [3:0]    r,
  output logic [3:0]    g,
  output logic [3:0]    b
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] HLast    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HActive  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActive  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HsStart  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HsEnd    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VsStart  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VsEnd    = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic tick;

  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_clk_en_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          pix_en_q, line_start_q, frame_start_q;
  logic          h_wrap;

  // Next position and its decode; only committed on a tick edge.
  always_comb begin
    h_wrap   = (h_q == HLast);
    h_d      = h_wrap ? '0 : h_q + CW'(1);
    v_d      = v_q;
    if (h_wrap) begin
      v_d = (v_q == VLast) ? '0 : v_q + CW'(1);
    end
    hsync_d  = ((h_d >= HsStart) && (h_d < HsEnd)) ? HS_POL : ~HS_POL;
    vsync_d  = ((v_d >= VsStart) && (v_d < VsEnd)) ? VS_POL : ~VS_POL;
    active_d = (h_d < HActive) && (v_d < VActive);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q           <= HLast;
      v_q           <= VLast;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      active_q      <= 1'b0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (tick) begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pix_en_q      <= 1'b1;
      line_start_q  <= (h_d == '0);
      frame_start_q <= (h_d == '0) && (v_d == '0);
    end else begin
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign pix_en      = pix_en_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign x           = h_q;
  assign y           = v_q;

`ifdef VGA_TEST_PATTERN_EN
  // Bars are H_ACTIVE/8 wide; any remainder pixels fold into the last bar.
  localparam int unsigned BarW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [CW-1:0] bar_idx;
  logic [2:0]    bar_sel;
  logic [11:0]   rgb_d, rgb_q;

  always_comb begin
    bar_idx = h_d / CW'(BarW);
    bar_sel = (bar_idx > CW'(7)) ? 3'd7 : bar_idx[2:0];
    rgb_d   = active_d ? bar_rgb(bar_sel) : 12'h000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q <= 12'h000;
    end else if (tick) begin
      rgb_q <= rgb_d;
    end
  end

  assign r = rgb_q[11:8];
  assign g = rgb_q[7:4];
  assign b = rgb_q[3:0];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: instance A uses the default 640x480 timing, instance B a
// tiny CLK_DIV=1 raster with positive sync. Expected outputs come from a closed-form
// model: clocks since reset release -> pixel steps -> linear raster index -> x/y.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic hs_a, vs_a, pe_a, act_a, ls_a, fs_a;
  logic hs_b, vs_b, pe_b, act_b, ls_b, fs_b;
  logic [10:0] x_a, y_a, x_b, y_b;
`ifdef VGA_TEST_PATTERN_EN
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  vga_timing_gen u_dut_a (
    .clk (clk), .rst_n (rst_a), .hsync (hs_a), .vsync (vs_a), .pix_en (pe_a),
    .active (act_a), .x (x_a), .y (y_a), .line_start (ls_a), .frame_start (fs_a)
`ifdef VGA_TEST_PATTERN_EN
    , .r (r_a), .g (g_a), .b (b_a)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV (1), .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1), .HS_POL (1'b1), .VS_POL (1'b1)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_b), .hsync (hs_b), .vsync (vs_b), .pix_en (pe_b),
    .active (act_b), .x (x_b), .y (y_b), .line_start (ls_b), .frame_start (fs_b)
`ifdef VGA_TEST_PATTERN_EN
    , .r (r_b), .g (g_b), .b (b_b)
`endif
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs, vs, pe, act, ls, fs;
    logic [11:0] rgb;
  } obs_t;

  typedef struct {
    int   n;    // clocks since reset release
    obs_t exp;
  } vec_t;

  int total, bad;
  int n_a, n_b;

  function automatic obs_t mk(int xx, int yy, bit hs, bit vs, bit pe, bit act, bit ls, bit fs,
                              logic [11:0] rgb);
    obs_t o;
    o.x = 11'(xx); o.y = 11'(yy);
    o.hs = hs; o.vs = vs; o.pe = pe; o.act = act; o.ls = ls; o.fs = fs;
    o.rgb = TP ? rgb : 12'h000;
    return o;
  endfunction

  function automatic logic [11:0] bar_colour(int bar);
    case (bar)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // n clocks after release there have been n/div pixel steps; the first step shows
  // raster index 0, so the index is (steps-1) mod frame size (reset = last index).
  function automatic obs_t model(int n, int div, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, bit hp, bit vp);
    int ht, vt, tot, k, lin, h, v, bar;
    bit pe, act, hs, vs;
    logic [11:0] rgb;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    tot = ht * vt;
    k   = n / div;
    lin = (k + tot - 1) % tot;
    h   = lin % ht;
    v   = lin / ht;
    pe  = (n > 0) && (n % div == 0);
    act = (h < ha) && (v < va);
    hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    vs  = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    rgb = 12'h000;
    if (act) begin
      bar = h / ((ha / 8 > 0) ? ha / 8 : 1);
      if (bar > 7) bar = 7;
      rgb = bar_colour(bar);
    end
    return mk(h, v, hs, vs, pe, act, pe && h == 0, pe && lin == 0, rgb);
  endfunction

  function automatic obs_t sample_a();
    obs_t o;
    o.x = x_a; o.y = y_a; o.hs = hs_a; o.vs = vs_a; o.pe = pe_a; o.act = act_a;
    o.ls = ls_a; o.fs = fs_a;
`ifdef VGA_TEST_PATTERN_EN
    o.rgb = {r_a, g_a, b_a};
`else
    o.rgb = 12'h000;
`endif
    return o;
  endfunction

  function automatic obs_t sample_b();
    obs_t o;
    o.x = x_b; o.y = y_b; o.hs = hs_b; o.vs = vs_b; o.pe = pe_b; o.act = act_b;
    o.ls = ls_b; o.fs = fs_b;
`ifdef VGA_TEST_PATTERN_EN
    o.rgb = {r_b, g_b, b_b};
`else
    o.rgb = 12'h000;
`endif
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("x=%0d y=%0d hs=%b vs=%b pe=%b act=%b ls=%b fs=%b rgb=%h",
                     o.x, o.y, o.hs, o.vs, o.pe, o.act, o.ls, o.fs, o.rgb);
  endfunction

  task automatic check(string name, obs_t got, obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got {%s} want {%s}", name, fmt(got), fmt(want));
    end
  endtask

  task automatic check_int(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One system clock; models track clocks since release, then both DUTs are checked.
  task automatic step();
    @(posedge clk);
    n_a = rst_a ? n_a + 1 : 0;
    n_b = rst_b ? n_b + 1 : 0;
    @(negedge clk);
    check("model_a", sample_a(), model(n_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    check("model_b", sample_b(), model(n_b, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1));
  endtask

  vec_t tbl[15];

  initial begin
    int k, per, pe_cnt, hs_cnt, vs_cnt;
    total = 0; bad = 0; n_a = 0; n_b = 0;

    // Default timing vectors, n = clocks since reset release.
    tbl[0]  = '{0,    mk(799, 524, 1, 1, 0, 0, 0, 0, 12'h000)};
    tbl[1]  = '{3,    mk(799, 524, 1, 1, 0, 0, 0, 0, 12'h000)};
    tbl[2]  = '{4,    mk(0,   0,   1, 1, 1, 1, 1, 1, 12'hFFF)};
    tbl[3]  = '{5,    mk(0,   0,   1, 1, 0, 1, 0, 0, 12'hFFF)};
    tbl[4]  = '{8,    mk(1,   0,   1, 1, 1, 1, 0, 0, 12'hFFF)};
    tbl[5]  = '{320,  mk(79,  0,   1, 1, 1, 1, 0, 0, 12'hFFF)};
    tbl[6]  = '{324,  mk(80,  0,   1, 1, 1, 1, 0, 0, 12'hFF0)};
    tbl[7]  = '{804,  mk(200, 0,   1, 1, 1, 1, 0, 0, 12'h0FF)};
    tbl[8]  = '{2244, mk(560, 0,   1, 1, 1, 1, 0, 0, 12'h000)};
    tbl[9]  = '{2560, mk(639, 0,   1, 1, 1, 1, 0, 0, 12'h000)};
    tbl[10] = '{2564, mk(640, 0,   1, 1, 1, 0, 0, 0, 12'h000)};
    tbl[11] = '{2628, mk(656, 0,   0, 1, 1, 0, 0, 0, 12'h000)};
    tbl[12] = '{3008, mk(751, 0,   0, 1, 1, 0, 0, 0, 12'h000)};
    tbl[13] = '{3012, mk(752, 0,   1, 1, 1, 0, 0, 0, 12'h000)};
    tbl[14] = '{3204, mk(0,   1,   1, 1, 1, 1, 1, 0, 12'hFFF)};

    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) step();
    rst_a = 1'b1; rst_b = 1'b1;

    for (int i = 0; i < 15; i++) begin
      while (n_a < tbl[i].n) step();
      check($sformatf("tbl%0d", i), sample_a(), tbl[i].exp);
    end

    // One full default line from its line_start: 800 pixels, hsync low for 96 of them.
    pe_cnt = 0; hs_cnt = 0;
    repeat (3200) begin
      step();
      if (pe_a) pe_cnt++;
      if (!hs_a) hs_cnt++;
    end
    check_int("line_pix_en", pe_cnt, 800);
    check_int("line_hsync_low_clks", hs_cnt, 384);
    check_int("line_y_after", int'(y_a), 2);

    // Reset for one clock mid-line, then restart from the top of frame.
    k = 0;
    while (!(x_a == 11'd300 && pe_a) && k < 4000) begin
      step();
      k++;
    end
    check_int("reach_x300_timeout", int'(k >= 4000), 0);
    rst_a = 1'b0;
    step();
    check("midreset_state", sample_a(), mk(799, 524, 1, 1, 0, 0, 0, 0, 12'h000));
    rst_a = 1'b1;
    repeat (3) step();
    check("midreset_wait", sample_a(), mk(799, 524, 1, 1, 0, 0, 0, 0, 12'h000));
    step();
    check("midreset_fs", sample_a(), mk(0, 0, 1, 1, 1, 1, 1, 1, 12'hFFF));

    // Small raster: one full frame between frame_start strobes.
    k = 0;
    while (!fs_b && k < 200) begin
      step();
      k++;
    end
    check_int("b_fs_timeout", int'(k >= 200), 0);
    per = 0; pe_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    do begin
      step();
      per++;
      if (pe_b) pe_cnt++;
      if (hs_b) hs_cnt++;
      if (vs_b) vs_cnt++;
    end while (!fs_b && per < 200);
    check_int("b_frame_clks", per, 98);
    check_int("b_pix_en_high", pe_cnt, 98);
    check_int("b_hsync_high", hs_cnt, 14);
    check_int("b_vsync_high", vs_cnt, 14);

    // Random resets on both instances, checked every clock against the model.
    repeat (4000) begin
      if ($urandom_range(0, 299) == 0) rst_a = 1'b0;
      else if (!rst_a && $urandom_range(0, 1) == 1) rst_a = 1'b1;
      if ($urandom_range(0, 99) == 0) rst_b = 1'b0;
      else if (!rst_b && $urandom_range(0, 1) == 1) rst_b = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
